// File: rtl/result_uart_pkg.sv
// Shared constants, FSM state type and frame byte selection for result_uart_tx.
package result_uart_pkg;

    localparam logic [7:0]  FRAME_HDR  = 8'hA5;
    localparam int unsigned NWORDS     = 16;
    localparam int unsigned WORD_W     = 12;
    localparam int unsigned DATA_BYTES = 32;

    typedef enum logic [2:0] {IDLE, LOAD, SEND, CSUM, FIN} state_e;

    // idx 0 is the header; idx 1..32 walk r1..r16 as {hi nibble, lo byte}.
    function automatic logic [7:0] frame_byte(input logic [NWORDS*WORD_W-1:0] snap,
                                              input logic [5:0]               idx);
        logic [4:0]        j;
        logic [WORD_W-1:0] w;
        j = idx[4:0] - 5'd1;
        w = snap[WORD_W*j[4:1] +: WORD_W];
        if (idx == 6'd0) begin
            return FRAME_HDR;
        end
        return j[0] ? w[7:0] : {4'h0, w[11:8]};
    endfunction

endpackage

// File: rtl/uart_tx_byte.sv
// 8N1 byte serialiser; go is accepted while idle or in the bdone cycle so bytes run back to back.
module uart_tx_byte #(
    parameter int unsigned CLKS_PER_BIT = 434
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       go,
    input  logic [7:0] tx_byte,
    output logic       tx,
    output logic       bdone
);

    localparam int unsigned BAUD_W = $clog2(CLKS_PER_BIT);

    logic              active_q, active_d;
    logic              tx_q, tx_d;
    logic [8:0]        shift_q, shift_d;
    logic [3:0]        bit_cnt_q, bit_cnt_d;
    logic [BAUD_W-1:0] baud_q, baud_d;
    logic              baud_last;

    assign baud_last = (baud_q == BAUD_W'(CLKS_PER_BIT - 1));
    assign bdone     = active_q && (bit_cnt_q == 4'd9) && baud_last;
    assign tx        = tx_q;

    always_comb begin
        active_d  = active_q;
        tx_d      = tx_q;
        shift_d   = shift_q;
        bit_cnt_d = bit_cnt_q;
        baud_d    = baud_q;
        if (go && (!active_q || bdone)) begin
            active_d  = 1'b1;
            tx_d      = 1'b0;
            shift_d   = {1'b1, tx_byte};
            bit_cnt_d = 4'd0;
            baud_d    = '0;
        end else if (active_q) begin
            if (baud_last) begin
                baud_d = '0;
                if (bit_cnt_q == 4'd9) begin
                    active_d  = 1'b0;
                    bit_cnt_d = 4'd0;
                    tx_d      = 1'b1;
                end else begin
                    // the stop bit is the 1 parked in shift_q[8]
                    bit_cnt_d = bit_cnt_q + 4'd1;
                    tx_d      = shift_q[0];
                    shift_d   = {1'b1, shift_q[8:1]};
                end
            end else begin
                baud_d = baud_q + BAUD_W'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            active_q  <= 1'b0;
            tx_q      <= 1'b1;
            shift_q   <= '0;
            bit_cnt_q <= '0;
            baud_q    <= '0;
        end else begin
            active_q  <= active_d;
            tx_q      <= tx_d;
            shift_q   <= shift_d;
            bit_cnt_q <= bit_cnt_d;
            baud_q    <= baud_d;
        end
    end

endmodule

// File: rtl/result_uart_tx.sv
// Snapshots r1..r16 on start and streams header + 32 data bytes over UART 8N1.
// Define RESULT_UART_CSUM_EN to append an XOR checksum byte of the data bytes.
module result_uart_tx
    import result_uart_pkg::*;
#(
    parameter int unsigned CLKS_PER_BIT = 434
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     start,
    input  logic [NWORDS*WORD_W-1:0] results,
    output logic                     tx,
    output logic                     busy,
    output logic                     done
);

    state_e                    state_q, state_d;
    logic [NWORDS*WORD_W-1:0]  snap_q, snap_d;
    logic [5:0]                byte_idx_q, byte_idx_d;
    logic                      kick_q, kick_d;
    logic                      go;
    logic                      bdone;
    logic [7:0]                tx_byte;
    logic [7:0]                nxt_byte;
`ifdef RESULT_UART_CSUM_EN
    logic [7:0]                csum_q, csum_d;
`endif

    // kick_q marks the first SEND cycle, which launches the header
    assign nxt_byte = frame_byte(snap_q, kick_q ? 6'd0 : byte_idx_q + 6'd1);
    assign busy     = (state_q == LOAD) || (state_q == SEND) || (state_q == CSUM);
    assign done     = (state_q == FIN);

    always_comb begin
        state_d    = state_q;
        snap_d     = snap_q;
        byte_idx_d = byte_idx_q;
        kick_d     = kick_q;
        go         = 1'b0;
        tx_byte    = nxt_byte;
`ifdef RESULT_UART_CSUM_EN
        csum_d     = csum_q;
`endif
        unique case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = LOAD;
                    snap_d  = results;
                end
            end
            LOAD: begin
                byte_idx_d = 6'd0;
                kick_d     = 1'b1;
                state_d    = SEND;
`ifdef RESULT_UART_CSUM_EN
                csum_d     = 8'h00;
`endif
            end
            SEND: begin
                if (kick_q) begin
                    go     = 1'b1;
                    kick_d = 1'b0;
                end else if (bdone) begin
                    if (byte_idx_q < 6'(DATA_BYTES)) begin
                        go         = 1'b1;
                        byte_idx_d = byte_idx_q + 6'd1;
`ifdef RESULT_UART_CSUM_EN
                        csum_d     = csum_q ^ nxt_byte;
`endif
                    end else begin
`ifdef RESULT_UART_CSUM_EN
                        state_d = CSUM;
                        go      = 1'b1;
                        tx_byte = csum_q;
`else
                        state_d = FIN;
`endif
                    end
                end
            end
            CSUM: begin
                if (bdone) begin
                    state_d = FIN;
                end
            end
            FIN: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            snap_q     <= '0;
            byte_idx_q <= '0;
            kick_q     <= 1'b0;
`ifdef RESULT_UART_CSUM_EN
            csum_q     <= '0;
`endif
        end else begin
            state_q    <= state_d;
            snap_q     <= snap_d;
            byte_idx_q <= byte_idx_d;
            kick_q     <= kick_d;
`ifdef RESULT_UART_CSUM_EN
            csum_q     <= csum_d;
`endif
        end
    end

    uart_tx_byte #(
        .CLKS_PER_BIT (CLKS_PER_BIT)
    ) u_byte (
        .clk     (clk),
        .rst_n   (rst_n),
        .go      (go),
        .tx_byte (tx_byte),
        .tx      (tx),
        .bdone   (bdone)
    );

endmodule

// File: tb/tb_result_uart_tx.sv
// Bench for result_uart_tx: UART receiver model feeding a byte scoreboard, plus frame timing checks.
module tb_result_uart_tx;

    localparam int CPB      = 4;
    localparam int BYTE_CYC = 10 * CPB;
`ifdef RESULT_UART_CSUM_EN
    localparam int NB = 34;
`else
    localparam int NB = 33;
`endif

    logic         clk     = 1'b0;
    logic         rst_n   = 1'b0;
    logic         start   = 1'b0;
    logic [191:0] results = '0;
    logic         tx, busy, done;

    int         n_vec = 0;
    int         n_err = 0;
    int         cyc   = 0;
    logic [7:0] exp_q[$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    result_uart_tx #(
        .CLKS_PER_BIT (CPB)
    ) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .start   (start),
        .results (results),
        .tx      (tx),
        .busy    (busy),
        .done    (done)
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic push_frame(input logic [191:0] r);
        logic [11:0] w;
        logic [7:0]  cs;
        cs = 8'h00;
        exp_q.push_back(8'hA5);
        for (int k = 0; k < 16; k++) begin
            w = r[12*k +: 12];
            exp_q.push_back({4'h0, w[11:8]});
            exp_q.push_back(w[7:0]);
            cs = cs ^ {4'h0, w[11:8]} ^ w[7:0];
        end
`ifdef RESULT_UART_CSUM_EN
        exp_q.push_back(cs);
`endif
    endtask

    // Receiver: detect start bit, sample each bit at its middle, drop bytes cut by reset.
    initial begin : rx_model
        logic [7:0] data;
        logic       ok;
        forever begin
            @(posedge clk); #1;
            if (rst_n && tx === 1'b0) begin
                ok   = 1'b1;
                data = '0;
                repeat (CPB / 2) begin @(posedge clk); #1; if (!rst_n) ok = 1'b0; end
                for (int i = 0; i < 8; i++) begin
                    repeat (CPB) begin @(posedge clk); #1; if (!rst_n) ok = 1'b0; end
                    data[i] = tx;
                end
                repeat (CPB) begin @(posedge clk); #1; if (!rst_n) ok = 1'b0; end
                if (ok) begin
                    check_eq("stop_bit", tx, 1);
                    check_eq("byte_expected", exp_q.size() > 0, 1);
                    if (exp_q.size() > 0) check_eq("rx_byte", data, exp_q.pop_front());
                end
            end
        end
    end

    task automatic run_frame(input logic [191:0] r, input bit mutate, input bit poke_mid,
                             input bit poke_done, input int abort_byte);
        int s, fall, done_at, n_done, lim;
        bit aborted;
        push_frame(r);
        results = r;
        start   = 1'b1;
        s       = cyc + 1;
        fall    = -1;
        done_at = -1;
        n_done  = 0;
        aborted = 1'b0;
        @(posedge clk); #1;
        start = 1'b0;
        if (mutate) results = {16{12'hFFF}};
        check_eq("busy_after_start", busy, 1);
        lim = 2 + NB * BYTE_CYC + 100;
        for (int n = 0; n < lim && !aborted; n++) begin
            @(posedge clk); #1;
            start = 1'b0;
            if (tx === 1'b0 && fall < 0) fall = cyc - s;
            if (done === 1'b1) begin
                n_done++;
                done_at = cyc - s;
                if (poke_done) start = 1'b1;
            end
            if (poke_mid && (cyc - s == 2 + 5 * BYTE_CYC + 10)) start = 1'b1;
            if (abort_byte >= 0 && (cyc - s == 2 + abort_byte * BYTE_CYC + 15)) begin
                #3 rst_n = 1'b0;
                #1;
                check_eq("abort_tx", tx, 1);
                check_eq("abort_busy", busy, 0);
                exp_q.delete();
                aborted = 1'b1;
            end
        end
        if (aborted) begin
            for (int n = 0; n < 63; n++) begin
                @(posedge clk); #1;
                if (n == 2) rst_n = 1'b1;
                if (done === 1'b1) n_done++;
            end
            check_eq("abort_no_done", n_done, 0);
            check_eq("abort_tx_idle", tx, 1);
            check_eq("abort_busy_idle", busy, 0);
        end else begin
            check_eq("tx_fall_latency", fall, 2);
            check_eq("done_latency", done_at, 2 + NB * BYTE_CYC);
            check_eq("done_count", n_done, 1);
            check_eq("bytes_left", exp_q.size(), 0);
            check_eq("busy_end", busy, 0);
            check_eq("tx_end", tx, 1);
        end
    endtask

    initial begin
        logic [191:0] p_inc, p_rnd, p_abc, p_123;
        for (int k = 1; k <= 16; k++) begin
            p_inc[12*(k-1) +: 12] = 12'(k * 12'h101);
            p_rnd[12*(k-1) +: 12] = 12'($urandom);
        end
        p_abc = {16{12'hABC}};
        p_123 = '0;
        p_123[11:0] = 12'h123;

        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        for (int n = 0; n < 200; n++) begin
            @(posedge clk); #1;
            check_eq("idle_tx", tx, 1);
            check_eq("idle_busy", busy, 0);
            check_eq("idle_done", done, 0);
        end

        run_frame(p_inc, 1'b0, 1'b0, 1'b0, -1);
        run_frame(p_rnd, 1'b1, 1'b0, 1'b0, -1);
        run_frame(p_inc, 1'b0, 1'b1, 1'b1, -1);
        run_frame(p_rnd, 1'b0, 1'b0, 1'b0, 10);
        run_frame(p_inc, 1'b0, 1'b0, 1'b0, -1);
        run_frame(p_abc, 1'b0, 1'b0, 1'b0, -1);
        run_frame(p_123, 1'b0, 1'b0, 1'b0, -1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
